xif_result_queue: RTL and testbench
===================================

# xif_result_queue

In-order result buffer for the custom coprocessor on the CV-X-IF. It sits directly downstream of the coprocessor issue/execute logic and upstream of the core's result interface. It holds each accepted instruction's result until the core's commit transaction for that ID arrives. It then returns committed results to the core in issue order and silently discards killed instructions.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- ID_WIDTH, 4, width of the XIF instruction ID
- DATA_WIDTH, 32, result data width (X_RFW)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; asynchronous, active-high
- enq_valid_i  in  1  upstream offers an accepted instruction's result
- enq_ready_o  out  1  queue can take an entry; equals (count_o != DEPTH)
- enq_id_i  in  ID_WIDTH  XIF instruction ID
- enq_rd_i  in  5  destination register
- enq_we_i  in  1  result writes rd
- enq_data_i  in  DATA_WIDTH  result value
- commit_valid_i  in  1  core commit transaction
- commit_id_i  in  ID_WIDTH  ID being committed or killed
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  head entry is committed and presented
- result_ready_i  in  1  core accepts the result
- result_id_o  out  ID_WIDTH  head ID
- result_rd_o  out  5  head rd
- result_we_o  out  1  head we
- result_data_o  out  DATA_WIDTH  head data
- count_o  out  $clog2(DEPTH+1)  number of live entries

## Operation

- Circular buffer with head/tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus a count register.
- Each entry holds id, rd, we, data and a state: PEND (waiting for commit), CMT (committed), or KILL.
- Enqueue fires when enq_valid_i && enq_ready_o. The entry is written at the tail with state PEND, and tail advances.
- Commit:
  - When commit_valid_i is high, every live entry whose id == commit_id_i and whose state is PEND moves to CMT, or to KILL if commit_kill_i is set.
  - A commit that matches no live PEND entry is ignored.
  - Commits to entries already in CMT or KILL are ignored.
- Same-cycle enqueue and commit with enq_id_i == commit_id_i: the new entry is written directly with state CMT or KILL. The commit is not lost.
- Head behaviour:
  - Head in CMT: result_valid_o = 1. Outputs come from the head entry's registers.
  - Head in KILL: the entry is popped on the next edge without asserting result_valid_o (one cycle per killed entry).
  - Head in PEND: result_valid_o = 0, and entries behind it wait, including committed ones (strict in-order).
- Pop fires on result_valid_o && result_ready_i, or on a KILL head. Head advances and count decrements.
- Enqueue and pop in the same cycle leave the count unchanged.
- Live IDs are unique; this is guaranteed upstream. A bench assertion flags an enqueue whose ID matches a live entry.

## Timing

- Reset (asynchronous): head = tail = 0, count_o = 0, all entries invalid, result_valid_o = 0, enq_ready_o = 1.
  - result_id_o, result_rd_o, result_we_o and result_data_o are 0 while the queue is empty.
- All outputs are functions of registers only. There is no combinational path from any input to any output.
- Latency:
  - Enqueue with same-cycle commit at edge N: result_valid_o is high in cycle N+1.
  - Commit one cycle after enqueue: result_valid_o rises one cycle after the commit edge.
- Once result_valid_o rises, it and all result_* fields stay stable until result_ready_i is sampled high (XIF rule).
- Full: enq_ready_o = 0 when count = DEPTH. A pop in that cycle does not raise enq_ready_o until the next cycle (no bypass).
- Empty: result_valid_o = 0; enqueue behaviour is unchanged.
- Reset mid-operation discards all entries immediately. No result is emitted after reset deassertion until a new enqueue and commit occur.

## Test plan

- Single op: enqueue id=3, rd=5, data=0xDEADBEEF; commit id=3 one cycle later; ready=1 → one result: id=3, rd=5, data=0xDEADBEEF. count_o returns to 0.
- Same-cycle commit: enqueue id=1 with commit_valid_i=1, commit_id_i=1 in the same cycle → result_valid_o is high on the next cycle.
- Ordering: enqueue ids 0, 1, 2; commit 2, then 1, then 0 → no result until id 0 is committed, then results 0, 1, 2 on consecutive cycles with ready held high.
- Kill: enqueue ids 4, 5, 6; kill 5; commit 4 and 6 → results for 4 and 6 only. Id 5 is dropped in one cycle, with no valid pulse.
- Full/backpressure: DEPTH=4, fill with ids 0–3, hold ready=0 after all commits → enq_ready_o=0 and result fields stable. Raise ready for one cycle → count 3, enq_ready_o=1 the following cycle. Pointers wrap correctly over 10 further ops.
- Reset mid-stream: 3 entries live with head committed; assert rst_i asynchronously → result_valid_o=0 and count_o=0 immediately, and enq_ready_o=1.

Source files
------------

// File: rtl/xif_result_queue_if.sv
// Handshake bundle between coprocessor issue logic, the core commit port and the result queue.
// Signal names keep the queue-side direction suffixes so both ends read the same.
interface xif_result_queue_if #(
  parameter int DEPTH      = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  enq_valid_i;
  logic                  enq_ready_o;
  logic [ID_WIDTH-1:0]   enq_id_i;
  logic [4:0]            enq_rd_i;
  logic                  enq_we_i;
  logic [DATA_WIDTH-1:0] enq_data_i;

  logic                  commit_valid_i;
  logic [ID_WIDTH-1:0]   commit_id_i;
  logic                  commit_kill_i;

  logic                  result_valid_o;
  logic                  result_ready_i;
  logic [ID_WIDTH-1:0]   result_id_o;
  logic [4:0]            result_rd_o;
  logic                  result_we_o;
  logic [DATA_WIDTH-1:0] result_data_o;

  logic [CW-1:0]         count_o;

  modport master (
    output enq_valid_i, enq_id_i, enq_rd_i, enq_we_i, enq_data_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output result_ready_i,
    input  enq_ready_o, result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o,
    input  count_o
  );

  modport slave (
    input  enq_valid_i, enq_id_i, enq_rd_i, enq_we_i, enq_data_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  result_ready_i,
    output enq_ready_o, result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o,
    output count_o
  );
endinterface

// File: rtl/xif_result_queue.sv
// In-order XIF result buffer: holds results until commit/kill, returns committed ones in issue order.
// Every output is decoded from registers only; no input reaches an output combinationally.
package xif_rq_pkg;
  typedef enum logic [1:0] {
    ST_INV  = 2'd0,
    ST_PEND = 2'd1,
    ST_CMT  = 2'd2,
    ST_KILL = 2'd3
  } st_e;
endpackage

module xif_rq_entry
  import xif_rq_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  st_e                   wr_st_i,
  input  logic [ID_WIDTH-1:0]   wr_id_i,
  input  logic [4:0]            wr_rd_i,
  input  logic                  wr_we_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  clr_i,
  input  logic                  cmt_valid_i,
  input  logic [ID_WIDTH-1:0]   cmt_id_i,
  input  logic                  cmt_kill_i,
  output st_e                   st_o,
  output logic [ID_WIDTH-1:0]   id_o,
  output logic [4:0]            rd_o,
  output logic                  we_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  st_e                   st_q, st_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [4:0]            rd_q, rd_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    st_d   = st_q;
    id_d   = id_q;
    rd_d   = rd_q;
    we_d   = we_q;
    data_d = data_q;
    // Only a pending entry reacts; repeated commits/kills to a resolved ID are dropped.
    if (cmt_valid_i && st_q == ST_PEND && id_q == cmt_id_i)
      st_d = cmt_kill_i ? ST_KILL : ST_CMT;
    if (clr_i)
      st_d = ST_INV;
    if (wr_i) begin
      st_d   = wr_st_i;
      id_d   = wr_id_i;
      rd_d   = wr_rd_i;
      we_d   = wr_we_i;
      data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q   <= ST_INV;
      id_q   <= '0;
      rd_q   <= '0;
      we_q   <= 1'b0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      id_q   <= id_d;
      rd_q   <= rd_d;
      we_q   <= we_d;
      data_q <= data_d;
    end
  end

  assign st_o   = st_q;
  assign id_o   = id_q;
  assign rd_o   = rd_q;
  assign we_o   = we_q;
  assign data_o = data_q;
endmodule

module xif_result_queue
  import xif_rq_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  xif_result_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  st_e  [DEPTH-1:0]                 ent_st;
  logic [DEPTH-1:0][ID_WIDTH-1:0]   ent_id;
  logic [DEPTH-1:0][4:0]            ent_rd;
  logic [DEPTH-1:0]                 ent_we;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq_ready, enq_fire, pop, head_live;
  st_e           enq_st, head_st;

  assign enq_ready = (count_q != CW'(DEPTH));
  assign enq_fire  = q.enq_valid_i && enq_ready;
  assign head_st   = ent_st[head_q];
  assign head_live = (head_st != ST_INV);
  // A killed head drains on its own, one entry per cycle, never shown to the core.
  assign pop       = (head_st == ST_CMT && q.result_ready_i) || head_st == ST_KILL;

  // A commit arriving alongside its own enqueue lands directly in the new entry.
  always_comb begin
    enq_st = ST_PEND;
    if (q.commit_valid_i && q.commit_id_i == q.enq_id_i)
      enq_st = q.commit_kill_i ? ST_KILL : ST_CMT;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    xif_rq_entry #(
      .ID_WIDTH  (ID_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ent (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_i       (enq_fire && tail_q == PW'(i)),
      .wr_st_i    (enq_st),
      .wr_id_i    (q.enq_id_i),
      .wr_rd_i    (q.enq_rd_i),
      .wr_we_i    (q.enq_we_i),
      .wr_data_i  (q.enq_data_i),
      .clr_i      (pop && head_q == PW'(i)),
      .cmt_valid_i(q.commit_valid_i),
      .cmt_id_i   (q.commit_id_i),
      .cmt_kill_i (q.commit_kill_i),
      .st_o       (ent_st[i]),
      .id_o       (ent_id[i]),
      .rd_o       (ent_rd[i]),
      .we_o       (ent_we[i]),
      .data_o     (ent_data[i])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)      head_d = head_q + PW'(1);
    if (enq_fire) tail_d = tail_q + PW'(1);
    count_d = count_q + CW'(enq_fire) - CW'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign q.enq_ready_o    = enq_ready;
  assign q.result_valid_o = (head_st == ST_CMT);
  assign q.result_id_o    = head_live ? ent_id[head_q]   : '0;
  assign q.result_rd_o    = head_live ? ent_rd[head_q]   : '0;
  assign q.result_we_o    = head_live && ent_we[head_q];
  assign q.result_data_o  = head_live ? ent_data[head_q] : '0;
  assign q.count_o        = count_q;
endmodule

// File: tb/tb_xif_result_queue.sv
// Directed bench for xif_result_queue: ordering, same-cycle commit, kill, full/wrap, async reset.
module tb_xif_result_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] live = '0;

  xif_result_queue_if #(.DEPTH(4), .ID_WIDTH(4), .DATA_WIDTH(32)) bus ();

  xif_result_queue #(.DEPTH(4), .ID_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .q    (bus)
  );

  always #5 clk = ~clk;

  // Live IDs must be unique at enqueue time.
  always @(posedge clk) begin
    if (rst) live <= '0;
    else begin
      if (bus.result_valid_o && bus.result_ready_i) live[bus.result_id_o] <= 1'b0;
      if (bus.commit_valid_i && bus.commit_kill_i) live[bus.commit_id_i] <= 1'b0;
      if (bus.enq_valid_i && bus.enq_ready_o) begin
        if (live[bus.enq_id_i]) begin
          bad++;
          $display("FAIL dup_live_id got id=%0d already live, required unique", bus.enq_id_i);
        end
        live[bus.enq_id_i] <= 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enq_valid_i    = 1'b0;
    bus.enq_id_i       = '0;
    bus.enq_rd_i       = '0;
    bus.enq_we_i       = 1'b0;
    bus.enq_data_i     = '0;
    bus.commit_valid_i = 1'b0;
    bus.commit_id_i    = '0;
    bus.commit_kill_i  = 1'b0;
    bus.result_ready_i = 1'b0;
  endtask

  task automatic enq(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] data);
    bus.enq_valid_i = 1'b1;
    bus.enq_id_i    = id;
    bus.enq_rd_i    = rd;
    bus.enq_we_i    = 1'b1;
    bus.enq_data_i  = data;
  endtask

  task automatic cmt(input logic [3:0] id, input logic kill);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = id;
    bus.commit_kill_i  = kill;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.result_valid_o); end
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.enq_ready_o !== 1'b1) begin bad++; $display("FAIL rst_enq_ready got=%b exp=1", bus.enq_ready_o); end
    total++; if (bus.result_data_o !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.result_data_o); end
    total++; if (bus.result_id_o !== 4'h0) begin bad++; $display("FAIL rst_id got=%h exp=0", bus.result_id_o); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    idle();
    bus.result_ready_i = 1'b1;
    enq(4'd3, 5'd5, 32'hDEADBEEF);
    cyc();
    total++; if (bus.count_o !== 3'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", bus.count_o); end
    total++; if (bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL single_pend_valid got=%b exp=0", bus.result_valid_o); end
    bus.enq_valid_i = 1'b0;
    cmt(4'd3, 1'b0);
    cyc();
    bus.commit_valid_i = 1'b0;
    total++; if (bus.result_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.result_valid_o); end
    total++; if (bus.result_id_o !== 4'd3) begin bad++; $display("FAIL single_id got=%0d exp=3", bus.result_id_o); end
    total++; if (bus.result_rd_o !== 5'd5) begin bad++; $display("FAIL single_rd got=%0d exp=5", bus.result_rd_o); end
    total++; if (bus.result_we_o !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", bus.result_we_o); end
    total++; if (bus.result_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h exp=deadbeef", bus.result_data_o); end
    cyc();
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", bus.count_o); end
    total++; if (bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL single_done_valid got=%b exp=0", bus.result_valid_o); end
  endtask

  task automatic test_same_cycle();
    idle();
    enq(4'd1, 5'd9, 32'h0000_0011);
    cmt(4'd1, 1'b0);
    cyc();
    idle();
    total++; if (bus.result_valid_o !== 1'b1) begin bad++; $display("FAIL same_valid got=%b exp=1", bus.result_valid_o); end
    total++; if (bus.result_id_o !== 4'd1) begin bad++; $display("FAIL same_id got=%0d exp=1", bus.result_id_o); end
    total++; if (bus.result_data_o !== 32'h11) begin bad++; $display("FAIL same_data got=%h exp=11", bus.result_data_o); end
    bus.result_ready_i = 1'b1;
    cyc();
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL same_count got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_ordering();
    idle();
    bus.result_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enq(4'(i), 5'(i + 10), 32'hC000_0000 + 32'(i));
      cyc();
    end
    bus.enq_valid_i = 1'b0;
    cmt(4'd2, 1'b0);
    cyc();
    total++; if (bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL ord_wait2 got=%b exp=0", bus.result_valid_o); end
    cmt(4'd1, 1'b0);
    cyc();
    total++; if (bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL ord_wait1 got=%b exp=0", bus.result_valid_o); end
    cmt(4'd0, 1'b0);
    cyc();
    bus.commit_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'(i)) begin bad++; $display("FAIL ord_result%0d got valid=%b id=%0d exp valid=1 id=%0d", i, bus.result_valid_o, bus.result_id_o, i); end
      total++; if (bus.result_data_o !== 32'hC000_0000 + 32'(i)) begin bad++; $display("FAIL ord_data%0d got=%h exp=%h", i, bus.result_data_o, 32'hC000_0000 + 32'(i)); end
      cyc();
    end
    total++; if (bus.count_o !== 3'd0 || bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL ord_empty got count=%0d valid=%b exp count=0 valid=0", bus.count_o, bus.result_valid_o); end
  endtask

  task automatic test_kill();
    idle();
    bus.result_ready_i = 1'b1;
    for (int i = 4; i < 7; i++) begin
      enq(4'(i), 5'(i), 32'hB000_0000 + 32'(i));
      cyc();
    end
    bus.enq_valid_i = 1'b0;
    cmt(4'd5, 1'b1);
    cyc();
    cmt(4'd4, 1'b0);
    cyc();
    total++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd4) begin bad++; $display("FAIL kill_r4 got valid=%b id=%0d exp valid=1 id=4", bus.result_valid_o, bus.result_id_o); end
    cmt(4'd6, 1'b0);
    cyc();
    bus.commit_valid_i = 1'b0;
    total++; if (bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL kill_no_pulse got=%b exp=0", bus.result_valid_o); end
    total++; if (bus.count_o !== 3'd2) begin bad++; $display("FAIL kill_count2 got=%0d exp=2", bus.count_o); end
    cyc();
    total++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd6) begin bad++; $display("FAIL kill_r6 got valid=%b id=%0d exp valid=1 id=6", bus.result_valid_o, bus.result_id_o); end
    total++; if (bus.count_o !== 3'd1) begin bad++; $display("FAIL kill_count1 got=%0d exp=1", bus.count_o); end
    cyc();
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL kill_count0 got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_full_wrap();
    idle();
    for (int i = 0; i < 4; i++) begin
      enq(4'(i), 5'(i + 1), 32'h1000 + 32'(i));
      cmt(4'(i), 1'b0);
      cyc();
    end
    bus.commit_valid_i = 1'b0;
    total++; if (bus.count_o !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", bus.count_o); end
    total++; if (bus.enq_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", bus.enq_ready_o); end
    enq(4'd9, 5'd9, 32'h9999);
    cyc();
    total++; if (bus.count_o !== 3'd4) begin bad++; $display("FAIL full_refuse got=%0d exp=4", bus.count_o); end
    total++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd0 || bus.result_data_o !== 32'h1000) begin bad++; $display("FAIL full_stable got valid=%b id=%0d data=%h exp valid=1 id=0 data=1000", bus.result_valid_o, bus.result_id_o, bus.result_data_o); end
    bus.result_ready_i = 1'b1;
    cyc();
    bus.result_ready_i = 1'b0;
    bus.enq_valid_i = 1'b0;
    total++; if (bus.count_o !== 3'd3) begin bad++; $display("FAIL full_no_bypass got count=%0d exp=3", bus.count_o); end
    total++; if (bus.enq_ready_o !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%b exp=1", bus.enq_ready_o); end
    total++; if (bus.result_id_o !== 4'd1) begin bad++; $display("FAIL full_head1 got=%0d exp=1", bus.result_id_o); end
    bus.result_ready_i = 1'b1;
    cyc();
    total++; if (bus.result_id_o !== 4'd2) begin bad++; $display("FAIL full_head2 got=%0d exp=2", bus.result_id_o); end
    cyc();
    total++; if (bus.result_id_o !== 4'd3 || bus.result_rd_o !== 5'd4) begin bad++; $display("FAIL full_head3 got id=%0d rd=%0d exp id=3 rd=4", bus.result_id_o, bus.result_rd_o); end
    cyc();
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", bus.count_o); end
    // Ten more single-cycle round trips walk the pointers around the ring.
    for (int k = 0; k < 10; k++) begin
      enq(4'(k), 5'(k), 32'hA500_0000 | 32'(k));
      cmt(4'(k), 1'b0);
      cyc();
      total++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'(k) || bus.result_data_o !== (32'hA500_0000 | 32'(k)) || bus.count_o !== 3'd1) begin
        bad++; $display("FAIL wrap%0d got valid=%b id=%0d data=%h count=%0d exp valid=1 id=%0d data=%h count=1", k, bus.result_valid_o, bus.result_id_o, bus.result_data_o, bus.count_o, k, 32'hA500_0000 | 32'(k));
      end
    end
    bus.enq_valid_i    = 1'b0;
    bus.commit_valid_i = 1'b0;
    cyc();
    total++; if (bus.count_o !== 3'd0 || bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL wrap_end got count=%0d valid=%b exp count=0 valid=0", bus.count_o, bus.result_valid_o); end
  endtask

  task automatic test_reset_mid();
    idle();
    enq(4'd7, 5'd7, 32'h7777);
    cmt(4'd7, 1'b0);
    cyc();
    bus.commit_valid_i = 1'b0;
    enq(4'd8, 5'd8, 32'h8888);
    cyc();
    enq(4'd9, 5'd9, 32'h9999);
    cyc();
    idle();
    total++; if (bus.count_o !== 3'd3 || bus.result_valid_o !== 1'b1) begin bad++; $display("FAIL rmid_pre got count=%0d valid=%b exp count=3 valid=1", bus.count_o, bus.result_valid_o); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", bus.result_valid_o); end
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.enq_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", bus.enq_ready_o); end
    total++; if (bus.result_data_o !== 32'h0) begin bad++; $display("FAIL rmid_data got=%h exp=0", bus.result_data_o); end
    #2 rst = 1'b0;
    bus.result_ready_i = 1'b1;
    repeat (2) cyc();
    total++; if (bus.result_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin bad++; $display("FAIL rmid_after got valid=%b count=%0d exp valid=0 count=0", bus.result_valid_o, bus.count_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_ordering();
    test_kill();
    test_full_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
